// File: rtl/log2_pkg.sv
// Shared constants and the round-robin pick helper for the Log2_32 request arbiter.
package log2_pkg;

    localparam int LOG2_DATA_W = 32;
    localparam int LOG2_RES_W  = 5;
    localparam int RR_MAX_REQ  = 16;
    localparam int RR_PTR_W    = 4;

    // Scans from ptr upward, wrapping at RR_MAX_REQ; unused high requesters must be zero,
    // which makes this equivalent to wrapping at the real requester count.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [RR_PTR_W-1:0]   ptr
    );
        logic [RR_MAX_REQ-1:0] grant;
        logic [RR_PTR_W-1:0]   idx;
        logic                  found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            idx = ptr + RR_PTR_W'(i);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/Log2_32.sv
// Combinational highest-set-bit encoder for a 32-bit operand; yields 0 for a zero operand.
module Log2_32
    import log2_pkg::*;
(
    input  logic [LOG2_DATA_W-1:0] data,
    output logic [LOG2_RES_W-1:0]  log2
);

    always_comb begin
        log2 = '0;
        for (int i = 0; i < LOG2_DATA_W; i++) begin
            if (data[i]) log2 = LOG2_RES_W'(i);
        end
    end

endmodule

// File: rtl/log2_arbiter.sv
// Round-robin arbiter sharing one Log2_32 among NUM_REQ valid/ready requesters,
// with a single registered response slot tagged by requester ID.
module log2_arbiter
    import log2_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*LOG2_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [LOG2_RES_W-1:0]          rsp_log2,
    output logic                           rsp_zero,
    output logic [ID_W-1:0]                rsp_id
);

    logic [LOG2_DATA_W-1:0] op_p1;
    logic [ID_W-1:0]        id_p1;
    logic                   zero_p1;
    logic                   vld_p1;
    logic [ID_W-1:0]        ptr_p1;

    logic                   slot_free;
    logic [RR_MAX_REQ-1:0]  pick_all;
    logic                   pick_unused;
    logic [NUM_REQ-1:0]     grant;
    logic                   accept;
    logic [LOG2_DATA_W-1:0] sel_data;
    logic [ID_W-1:0]        sel_id;

    assign slot_free   = !vld_p1 || rsp_ready;
    assign pick_all    = rr_pick(RR_MAX_REQ'(req_valid), RR_PTR_W'(ptr_p1));
    assign pick_unused = |(pick_all >> NUM_REQ);
    assign grant       = slot_free ? pick_all[NUM_REQ-1:0] : '0;
    // Grants are suppressed while reset is asserted even though the slot reads as free.
    assign req_ready   = rst_n ? grant : '0;
    assign accept      = |req_ready;

    always_comb begin
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*LOG2_DATA_W +: LOG2_DATA_W];
                sel_id   = ID_W'(i);
            end
        end
    end

    // Stage p1: response slot and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p1   <= '0;
            id_p1   <= '0;
            zero_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            ptr_p1  <= '0;
        end else if (accept) begin
            op_p1   <= sel_data;
            id_p1   <= sel_id;
            zero_p1 <= (sel_data == '0);
            vld_p1  <= 1'b1;
            if (int'(sel_id) == NUM_REQ - 1) ptr_p1 <= '0;
            else                             ptr_p1 <= sel_id + ID_W'(1);
        end else if (vld_p1 && rsp_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    Log2_32 u_log2 (
        .data (op_p1),
        .log2 (rsp_log2)
    );

    assign rsp_valid = vld_p1;
    assign rsp_zero  = zero_p1;
    assign rsp_id    = id_p1;

endmodule

// File: tb/tb_log2_arbiter.sv
// Directed table plus randomised scoreboard bench for log2_arbiter (NUM_REQ=4).
module tb_log2_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [4:0]   rsp_log2;
    logic         rsp_zero;
    logic [1:0]   rsp_id;

    int checks   = 0;
    int failures = 0;

    log2_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_log2  (rsp_log2),
        .rsp_zero  (rsp_zero),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Requesters must hold valid until accepted.
    logic [3:0] pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else begin
            for (int i = 0; i < 4; i++)
                if (pend[i] && !req_valid[i]) chk($sformatf("protocol_hold_req%0d", i), 64'(req_valid[i]), 64'd1);
            pend <= req_valid & ~req_ready;
        end
    end

    function automatic logic [4:0] ref_log2(input logic [31:0] d);
        logic [4:0] r;
        r = 0;
        while (d > 32'd1) begin
            d = d >> 1;
            r = r + 5'd1;
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'h1 << $urandom_range(0, 31);
            2:       return $urandom;
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    typedef struct {
        logic [3:0]   valid;
        logic [127:0] data;
        logic         rr;
        logic [3:0]   exp_ready;
        logic         exp_rv;
        logic [4:0]   exp_log2;
        logic         exp_zero;
        logic [1:0]   exp_id;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [127:0] d, input logic rr,
                                input logic [3:0] er, input logic rv, input logic [4:0] lg,
                                input logic z, input logic [1:0] id);
        vec_t t;
        t.valid = v; t.data = d; t.rr = rr; t.exp_ready = er;
        t.exp_rv = rv; t.exp_log2 = lg; t.exp_zero = z; t.exp_id = id;
        return t;
    endfunction

    vec_t vecs[21];

    // Bench-side reference state for the randomised phase.
    int         model_ptr;
    logic       model_rv;
    logic [4:0] model_log2;
    logic       model_zero;
    logic [1:0] model_id;
    int         wait_cnt[4];
    int         max_wait;

    function automatic logic [3:0] model_pick(input logic [3:0] v, input int ptr, input logic rv, input logic rr);
        logic [3:0] g;
        int idx;
        g = '0;
        if (rv && !rr) return g;
        for (int k = 0; k < 4; k++) begin
            idx = (ptr + k) % 4;
            if (v[idx]) return 4'(1 << idx);
        end
        return g;
    endfunction

    initial begin
        logic [127:0] rrd;
        logic [3:0]   nv;
        logic [127:0] nd;
        logic [3:0]   exp_g;
        logic [3:0]   last_rdy;
        logic [31:0]  gd;
        int           gi;

        rrd = {32'hFFFFFFFF, 32'h000000FF, 32'h00000003, 32'h00000001};
        vecs[0]  = mk(4'b0100, {32'h0, 32'h80000000, 32'h0, 32'h0}, 1, 4'b0100, 1, 31, 0, 2);
        vecs[1]  = mk(4'b0000, 128'h0, 1, 4'b0000, 0, 31, 0, 2);
        vecs[2]  = mk(4'b0001, 128'h0, 1, 4'b0001, 1, 0, 1, 0);
        vecs[3]  = mk(4'b0001, 128'h1, 1, 4'b0001, 1, 0, 0, 0);
        vecs[4]  = mk(4'b0000, 128'h0, 1, 4'b0000, 0, 0, 0, 0);
        vecs[5]  = mk(4'b1000, {32'h4, 96'h0}, 1, 4'b1000, 1, 2, 0, 3);
        vecs[6]  = mk(4'b1111, rrd, 1, 4'b0001, 1, 0, 0, 0);
        vecs[7]  = mk(4'b1111, rrd, 1, 4'b0010, 1, 1, 0, 1);
        vecs[8]  = mk(4'b1111, rrd, 1, 4'b0100, 1, 7, 0, 2);
        vecs[9]  = mk(4'b1111, rrd, 1, 4'b1000, 1, 31, 0, 3);
        vecs[10] = mk(4'b1111, rrd, 1, 4'b0001, 1, 0, 0, 0);
        vecs[11] = mk(4'b1110, rrd, 1, 4'b0010, 1, 1, 0, 1);
        vecs[12] = mk(4'b1100, rrd, 1, 4'b0100, 1, 7, 0, 2);
        vecs[13] = mk(4'b1000, rrd, 1, 4'b1000, 1, 31, 0, 3);
        vecs[14] = mk(4'b0000, 128'h0, 1, 4'b0000, 0, 31, 0, 3);
        vecs[15] = mk(4'b0010, {64'h0, 32'h10, 32'h0}, 0, 4'b0010, 1, 4, 0, 1);
        vecs[16] = mk(4'b1000, {32'h7FFFFFFF, 96'h0}, 0, 4'b0000, 1, 4, 0, 1);
        vecs[17] = mk(4'b1000, {32'h7FFFFFFF, 96'h0}, 0, 4'b0000, 1, 4, 0, 1);
        vecs[18] = mk(4'b1000, {32'h7FFFFFFF, 96'h0}, 0, 4'b0000, 1, 4, 0, 1);
        vecs[19] = mk(4'b1000, {32'h7FFFFFFF, 96'h0}, 1, 4'b1000, 1, 30, 0, 3);
        vecs[20] = mk(4'b0000, 128'h0, 1, 4'b0000, 0, 30, 0, 3);

        // Reset with all requesters asserting valid.
        rst_n = 1'b0; req_valid = 4'hF; req_data = rrd; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 0);
        chk("reset_rsp_log2",  64'(rsp_log2), 0);
        chk("reset_rsp_zero",  64'(rsp_zero), 0);
        chk("reset_rsp_id",    64'(rsp_id), 0);
        chk("reset_req_ready", 64'(req_ready), 0);
        req_valid = '0;
        rst_n = 1'b1;

        // Reset arriving while a response is waiting.
        @(negedge clk);
        req_valid = 4'b0001; req_data = 128'h00010000; rsp_ready = 1'b0;
        #1 chk("midrst_ready", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        chk("midrst_rv_before", 64'(rsp_valid), 1);
        chk("midrst_log2_before", 64'(rsp_log2), 16);
        @(negedge clk);
        req_valid = '0; rst_n = 1'b0;
        #1;
        chk("midrst_async_rv", 64'(rsp_valid), 0);
        chk("midrst_async_log2", 64'(rsp_log2), 0);
        chk("midrst_async_ready", 64'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010; req_data = {64'h0, 32'h8, 32'h0}; rsp_ready = 1'b1;
        #1 chk("postrst_ready", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        chk("postrst_rv", 64'(rsp_valid), 1);
        chk("postrst_log2", 64'(rsp_log2), 3);
        chk("postrst_id", 64'(rsp_id), 1);
        chk("postrst_zero", 64'(rsp_zero), 0);

        // Directed table: single requester, zero operand, round-robin, backpressure.
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            req_valid = vecs[k].valid; req_data = vecs[k].data; rsp_ready = vecs[k].rr;
            #1 chk($sformatf("vec%0d_req_ready", k), 64'(req_ready), 64'(vecs[k].exp_ready));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_rsp_valid", k), 64'(rsp_valid), 64'(vecs[k].exp_rv));
            chk($sformatf("vec%0d_rsp_log2", k),  64'(rsp_log2),  64'(vecs[k].exp_log2));
            chk($sformatf("vec%0d_rsp_zero", k),  64'(rsp_zero),  64'(vecs[k].exp_zero));
            chk($sformatf("vec%0d_rsp_id", k),    64'(rsp_id),    64'(vecs[k].exp_id));
        end

        // Randomised phase against the bench reference model.
        model_ptr = 0; model_rv = 0; model_log2 = 30; model_zero = 0; model_id = 3;
        last_rdy = '0; max_wait = 0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            nv = req_valid; nd = req_data;
            for (int i = 0; i < 4; i++) begin
                if (!(req_valid[i] && !last_rdy[i])) begin
                    nv[i] = 1'($urandom_range(0, 1));
                    nd[32*i +: 32] = rnd_data();
                end
            end
            req_valid = nv; req_data = nd; rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_g = model_pick(req_valid, model_ptr, model_rv, rsp_ready);
            chk($sformatf("rand%0d_req_ready", c), 64'(req_ready), 64'(exp_g));
            if (rsp_valid && !rsp_ready) chk($sformatf("rand%0d_full_no_grant", c), 64'(req_ready), 0);
            last_rdy = req_ready;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || req_ready[i]) wait_cnt[i] = 0;
                else if (|req_ready) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
            @(posedge clk); #1;
            if (exp_g != 0) begin
                gi = 0;
                for (int i = 0; i < 4; i++) if (exp_g[i]) gi = i;
                gd = req_data[32*gi +: 32];
                model_rv = 1; model_log2 = ref_log2(gd); model_zero = (gd == 0);
                model_id = 2'(gi); model_ptr = (gi + 1) % 4;
            end else if (model_rv && rsp_ready) begin
                model_rv = 0;
            end
            chk($sformatf("rand%0d_rsp_valid", c), 64'(rsp_valid), 64'(model_rv));
            chk($sformatf("rand%0d_rsp_log2", c),  64'(rsp_log2),  64'(model_log2));
            chk($sformatf("rand%0d_rsp_zero", c),  64'(rsp_zero),  64'(model_zero));
            chk($sformatf("rand%0d_rsp_id", c),    64'(rsp_id),    64'(model_id));
        end
        chk("rand_fairness_max_wait_ok", 64'(max_wait < NUM_REQ), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/log2_arbiter.md
Name: log2_arbiter

Overview:
- Shares one Log2_32 priority-encoder datapath among NUM_REQ requesters.
- Each requester gets a valid/ready request port; there is one valid/ready response port that is tagged with the requester ID.
- Arbitration is round-robin, with a single registered response slot.
- Sits between client engines, such as normalisers and FP converters, and the existing combinational Log2_32.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of the requester ID; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_data  input  NUM_REQ*32  per-requester operand; requester i uses bits [32*i+31:32*i].
- req_ready  output  NUM_REQ  one-hot grant; the request is accepted on a cycle where req_valid[i] && req_ready[i].
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_log2  output  5  index of the highest set bit of the accepted operand; 0 when the operand is 0.
- rsp_zero  output  1  accepted operand was 0, so rsp_log2 = 0 is not meaningful.
- rsp_id  output  ID_W  index of the requester that produced this response.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_log2=0, rsp_zero=0, rsp_id=0.
  - Operand register = 0, round-robin pointer = 0.
  - req_ready = 0 while rst_n=0.
  - Any response in flight is discarded, not replayed.
- Slot availability: slot_free = !rsp_valid || rsp_ready.
  - This allows one result per cycle when rsp_ready is held high.
- Grant, combinational:
  - If slot_free, scan req_valid starting at the pointer and wrapping modulo NUM_REQ.
  - The first asserted requester g gets req_ready[g]=1; all other bits are 0.
  - If slot is not free or no valid is asserted, req_ready = 0.
  - req_ready may depend on req_valid.
  - Requesters must hold req_valid and req_data stable until accepted; deasserting before acceptance is a protocol violation (bench assertion).
- Accept edge (grant to g):
  - Operand register ← req_data[g], rsp_id ← g, rsp_valid ← 1.
  - Pointer ← (g+1) mod NUM_REQ.
- Drain edge (rsp_valid && rsp_ready, no new grant):
  - rsp_valid ← 0.
  - rsp_log2, rsp_zero and rsp_id hold their last values.
- Simultaneous drain and accept: the new result replaces the old one; rsp_valid stays 1.
- No event: all state holds. The pointer moves only on a grant.
- rsp_log2 and rsp_zero:
  - rsp_log2 comes from Log2_32 driven by the operand register; it may be combinational after the register.
  - rsp_zero = (operand register == 0).
  - Both must be stable for the whole cycle rsp_valid is 1.
- Latency: accepted at edge N, rsp_valid=1 from edge N to edge N+1 and onwards until drained.
- Backpressure: while rsp_valid && !rsp_ready, req_ready = 0 and no state changes.
- Fairness: a requester that continuously asserts valid is granted within NUM_REQ grants.
- Pointer wrap: after a grant to NUM_REQ-1 the pointer becomes 0.

Decomposition:
- Shared package log2_pkg holds:
  - constants LOG2_DATA_W=32 and LOG2_RES_W=5;
  - function rr_pick(valid, ptr), which returns a one-hot grant.
- Sub-module: the existing Log2_32, instantiated once; it is not modified.
- All arbitration and response-slot logic lives in log2_arbiter.

Test Plan:
- Reset mid-operation:
  - Stimulus: req0 accepted with 0x00010000; assert rst_n=0 before rsp_ready.
  - Response: rsp_valid→0 immediately and asynchronously.
  - After release, req1=0x8 → rsp_log2=3, rsp_id=1; the pointer is 0 so req1 is granted first only because it is the sole valid.
- Single requester:
  - Stimulus: req2 valid with 0x80000000, rsp_ready=1.
  - Response: req_ready=4'b0100 in the same cycle; the next cycle shows rsp_valid=1, rsp_log2=31, rsp_id=2, rsp_zero=0.
- Zero operand:
  - Stimulus: req0 valid with 0x00000000.
  - Response: rsp_log2=0, rsp_zero=1.
  - Then req0 with 0x00000001 gives rsp_log2=0, rsp_zero=0.
- Round-robin:
  - Stimulus: all four valid continuously, with data 0x1, 0x3, 0xFF, 0xFFFFFFFF; rsp_ready=1; pointer starts at 0.
  - Response: grants in order 0,1,2,3,0; rsp_log2 sequence 0,1,7,31,0; one response per cycle.
- Backpressure:
  - Stimulus: req1=0x10 accepted; hold rsp_ready=0 for 3 cycles while req3=0x7FFFFFFF is valid.
  - Response: rsp_log2=4 stays stable with rsp_valid=1 and req_ready=0.
  - When rsp_ready=1, req3 is granted in that same cycle; the next response is rsp_log2=30, rsp_id=3.
- Randomised:
  - Stimulus: 1000 cycles of random valid/data/rsp_ready.
  - Response: every response matches the reference highest-set-bit function and has the correct ID.
  - No grant occurs while the slot is full, and no requester waits more than NUM_REQ grants.
